// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer:
// FSM state encoding, slice width and a parameter sanity check.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the counter can reach NIBBLES-1 and NIBBLES is in range.
    function automatic bit cnt_w_ok(int cnt_w, int nibbles);
        return (nibbles >= 1) && (nibbles <= 16) &&
               ((64'd1 << cnt_w) >= 64'(nibbles));
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_slice.sv
// nibble_add_slice: combinational 4-bit ripple adder of full-adder cells.
// Ports: a, b, ci in; s sum, co carry-out, c3 carry into bit 3.
module nibble_add_slice
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIBBLE_W];
    assign c3 = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer around one shared 4-bit slice.
// Ports: clk, rst_n; req_* valid/ready operand port; rsp_* result port; busy.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
    input  logic                        req_cin,
    input  logic                        req_sub,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_sum,
    output logic                        rsp_cout,
    output logic                        rsp_ovf,
    output logic                        busy
);

    localparam int W = NIBBLE_W * NIBBLES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    if (!cnt_w_ok(CNT_W, NIBBLES)) begin : g_bad_params
        $error("nibble_serial_add_ctrl: bad NIBBLES/CNT_W");
    end

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       sum_sh;
    logic               cout_q;
    logic               ovf_q;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;
    logic                slice_c3;

    nibble_add_slice u_slice (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_sh  <= req_a;
                        // Subtract as A + ~B + ~borrow.
                        b_sh  <= req_sub ? ~req_b : req_b;
                        carry <= req_cin ^ req_sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    // Result fills from the top so the LS nibble ends at bit 0.
                    sum_sh <= (sum_sh >> NIBBLE_W) |
                              (W'(slice_s) << (W - NIBBLE_W));
                    carry  <= slice_co;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cout_q <= slice_co;
                        ovf_q  <= slice_c3 ^ slice_co;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_sh;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

endmodule
